intpol2_d4_seq_ctrl: RTL and testbench
======================================

// Module: intpol2_D4_seq_ctrl
// PURPOSE
//  Sequencer for the D4 squared-interpolation datapath. Accepts input samples over a
//  valid/ready handshake, holds each sample on x2, and drives en_xi2/sel_xi2 so the
//  datapath emits N_PHASES interpolated values per sample. Emits out_valid aligned with
//  the datapath's registered xi2 and honours downstream backpressure.
// PARAMETERS
//  DATA_WIDTH  32  sample width before headroom
//  N_bits      2   headroom bits; x2 width = DATA_WIDTH+N_bits
//  N_PHASES    4   datapath steps per sample after the first (>=2); CW=$clog2(N_PHASES)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active-high
//  clear      in   1        synchronous soft clear, active-high
//  in_valid   in   1        input sample valid
//  in_ready   out  1        controller can accept a sample
//  in_data    in   DW+NB    signed input sample
//  x2         out  DW+NB    registered hold of the accepted sample, to datapath
//  en_xi2     out  1        datapath update enable (combinational from state)
//  sel_xi2    out  2        01=load x2, 10=x2<<2 seed, 11=recursive sum, 00=idle
//  dp_clear   out  1        one-cycle datapath clear pulse
//  out_valid  out  1        datapath xi2 holds a new value
//  out_ready  in   1        downstream accepts xi2
//  phase      out  CW       current phase index
//  busy       out  1        FSM not in IDLE
// BEHAVIOUR
//  Reset/clear: state=IDLE, x2=0, phase=0, out_valid=0, first=1, en_xi2=0, sel_xi2=00.
//   dp_clear=1 during rst and in the cycle after clear is sampled; 0 otherwise.
//   clear has priority over every other event, including an in-progress sequence.
//  can_issue = !out_valid || out_ready. en_xi2 = can_issue && state in {LOAD,SEED,ACC}.
//  IDLE: in_ready=1, sel=00. On in_valid: x2<=in_data; go LOAD if first, else SEED.
//  LOAD: sel=01. On issue: first<=0, go IDLE. One output for the first sample.
//  SEED: sel=10, phase=0. On issue: phase<=1, go ACC.
//  ACC:  sel=11. On issue: if phase==N_PHASES-1, phase<=0, go IDLE; else phase++.
//  in_ready=0 outside IDLE. x2 stable from acceptance until return to IDLE.
//  out_valid: set the cycle after any en_xi2 (xi2 latency 1). Cleared on out_ready
//   when no new issue occurs. Held while out_ready=0; en_xi2 is then withheld, so
//   xi2 does not change.
//  Throughput with out_ready tied high: N_PHASES+1 cycles/sample (incl. IDLE accept).
//  No arithmetic in this block. sel_xi2 is never 00 while en_xi2=1.
//  Unused phase states are unreachable; the default branch returns to IDLE.
// STRUCTURE
//  Package intpol2_D4_pkg: state enum {IDLE,LOAD,SEED,ACC}, SEL_IDLE/SEL_LOAD/SEL_SEED/
//   SEL_SUM 2-bit constants. Shared with the datapath top.
//  Single module: FSM + phase counter + sample register + output-valid flag.
//  No sub-module. Top level instantiates this block next to intpol2_D4_squared.
// TESTING
//  Reset -> all outputs at reset values, dp_clear=1, in_ready=1 after rst falls.
//  First sample 5, out_ready=1 -> one en_xi2 with sel=01; out_valid the next cycle;
//   datapath xi2=5.
//  Second sample 3, out_ready=1 -> sel sequence 10,11,11,11 on 4 consecutive cycles;
//   phase 0..3; back to IDLE.
//  out_ready low for 3 cycles during ACC phase 2 -> en_xi2=0 and phase/xi2 frozen;
//   resumes on the release cycle.
//  clear asserted in ACC phase 1 -> next cycle IDLE, dp_clear=1, out_valid=0; the next
//   sample takes the LOAD path.
//  in_valid held high continuously -> exactly one accept per N_PHASES+1 cycles; x2
//   never changes mid-sequence.

Source files
------------

// File: rtl/intpol2_d4_seq_ctrl_pkg.sv
// Shared definitions for the D4 squared-interpolation sequencer and datapath.
// Holds the controller state encoding and the datapath select codes.
// Imported by the sequencer and by the datapath top level.
package intpol2_d4_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEED = 2'd2,
      ACC  = 2'd3
   } state_t;

   // sel_xi2 codes understood by the datapath
   localparam logic [1:0] SEL_IDLE = 2'b00;  // hold
   localparam logic [1:0] SEL_LOAD = 2'b01;  // xi2 <= x2
   localparam logic [1:0] SEL_SEED = 2'b10;  // xi2 <= x2 << 2
   localparam logic [1:0] SEL_SUM  = 2'b11;  // xi2 <= recursive sum

endpackage

// File: rtl/intpol2_d4_seq_ctrl.sv
// Sequencer for the D4 squared-interpolation datapath: one step for the first
// sample, N_PHASES steps (seed + accumulate) for every later sample.
// en_xi2 is withheld while out_valid is set and out_ready is low, freezing xi2.
module intpol2_d4_seq_ctrl
   import intpol2_d4_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int N_bits     = 2,
   parameter int N_PHASES   = 4,
   localparam int CW        = $clog2(N_PHASES),
   localparam int XW        = DATA_WIDTH + N_bits
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [XW-1:0] in_data,
   output logic [XW-1:0] x2,
   output logic          en_xi2,
   output logic [1:0]    sel_xi2,
   output logic          dp_clear,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] phase,
   output logic          busy
);

   state_t state, state_nxt;
   logic   first;
   logic   clear_q;
   logic   accept;
   logic   can_issue;
   logic   last_phase;

   assign can_issue  = !out_valid || out_ready;
   assign last_phase = (phase == CW'(N_PHASES - 1));
   assign busy       = (state != IDLE);
   assign dp_clear   = rst || clear_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state, datapath enable/select and input handshake
   always_comb begin
      state_nxt = state;
      en_xi2    = 1'b0;
      sel_xi2   = SEL_IDLE;
      in_ready  = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid && !clear) begin
               accept    = 1'b1;
               state_nxt = first ? LOAD : SEED;
            end
         end
         LOAD: begin
            sel_xi2 = SEL_LOAD;
            en_xi2  = can_issue;
            if (can_issue) state_nxt = IDLE;
         end
         SEED: begin
            sel_xi2 = SEL_SEED;
            en_xi2  = can_issue;
            if (can_issue) state_nxt = ACC;
         end
         ACC: begin
            sel_xi2 = SEL_SUM;
            en_xi2  = can_issue;
            if (can_issue && last_phase) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Soft clear overrides any sequence in flight
      if (clear) state_nxt = IDLE;
   end

   // Sample hold: captured on acceptance, stable until the sequence ends
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         x2 <= '0;
      else if (clear)  x2 <= '0;
      else if (accept) x2 <= in_data;
   end

   // Phase counter: seed step is phase 0, accumulate steps are 1..N_PHASES-1
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                           phase <= '0;
      else if (clear)                    phase <= '0;
      else if (en_xi2 && state == SEED)  phase <= CW'(1);
      else if (en_xi2 && state == ACC)   phase <= last_phase ? '0 : phase + 1'b1;
   end

   // First-sample flag: the very first sample after reset/clear takes the LOAD path
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          first <= 1'b1;
      else if (clear)                   first <= 1'b1;
      else if (en_xi2 && state == LOAD) first <= 1'b0;
   end

   // xi2 is registered one cycle after en_xi2; valid holds until taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            out_valid <= 1'b0;
      else if (clear)     out_valid <= 1'b0;
      else if (en_xi2)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
   end

   // Datapath clear pulse for the cycle following a sampled soft clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) clear_q <= 1'b0;
      else     clear_q <= clear;
   end

endmodule

// File: tb/tb_intpol2_d4_seq_ctrl.sv
// Bench for the D4 sequencer: directed scenarios followed by random traffic.
// Expected behaviour comes from a queue-of-pending-steps model of the protocol.
// Outputs sampled on the falling edge; inputs driven 1 time unit after rising edge.
module tb_intpol2_d4_seq_ctrl;
   localparam int DW = 32;
   localparam int NB = 2;
   localparam int NP = 4;
   localparam int CW = $clog2(NP);
   localparam int XW = DW + NB;

   logic          clk = 1'b0;
   logic          rst, clear, in_valid, in_ready, en_xi2, dp_clear, out_valid, out_ready, busy;
   logic [XW-1:0] in_data, x2;
   logic [1:0]    sel_xi2;
   logic [CW-1:0] phase;

   intpol2_d4_seq_ctrl #(.DATA_WIDTH(DW), .N_bits(NB), .N_PHASES(NP)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .x2(x2), .en_xi2(en_xi2), .sel_xi2(sel_xi2), .dp_clear(dp_clear),
      .out_valid(out_valid), .out_ready(out_ready), .phase(phase), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: each accepted sample enqueues the datapath steps it owes
   typedef struct { logic [1:0] sel; int ph; } step_t;
   step_t         q[$];
   bit            m_ov, m_first, m_clr;
   logic [XW-1:0] m_x2;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int acc_cyc[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      q.delete(); m_ov = 0; m_first = 1; m_clr = 0; m_x2 = '0;
   endtask

   // One clock: check outputs against the model, then advance the model
   task automatic cycle();
      bit         en_exp, idle;
      logic [1:0] sel_exp;
      int         ph_exp;
      @(negedge clk);
      idle    = (q.size() == 0);
      en_exp  = !idle && (!m_ov || out_ready);
      sel_exp = idle ? 2'b00 : q[0].sel;
      ph_exp  = idle ? 0 : q[0].ph;
      chk("in_ready",  64'(in_ready),  64'(idle));
      chk("busy",      64'(busy),      64'(!idle));
      chk("en_xi2",    64'(en_xi2),    64'(en_exp));
      chk("sel_xi2",   64'(sel_xi2),   64'(sel_exp));
      chk("phase",     64'(phase),     64'(ph_exp));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("x2",        64'(x2),        64'(m_x2));
      chk("dp_clear",  64'(dp_clear),  64'(rst || m_clr));
      if (in_valid && in_ready && !clear && !rst) acc_cyc.push_back(cyc);
      @(posedge clk);
      if (rst) model_reset();
      else if (clear) begin
         model_reset(); m_clr = 1;
      end else begin
         m_clr = 0;
         if (en_exp) begin
            if (q[0].sel == 2'b01) m_first = 0;
            void'(q.pop_front());
         end
         m_ov = en_exp ? 1'b1 : (out_ready ? 1'b0 : m_ov);
         if (idle && in_valid) begin
            m_x2 = in_data;
            if (m_first) q.push_back('{2'b01, 0});
            else begin
               q.push_back('{2'b10, 0});
               for (int p = 1; p < NP; p++) q.push_back('{2'b11, p});
            end
         end
      end
      cyc++;
      #1;
   endtask

   task automatic send(input logic [XW-1:0] d);
      in_valid = 1; in_data = d;
      cycle();
      in_valid = 0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
      cycle();
      chk(tag, 64'(q.size()), 64'd0);
   endtask

   task automatic wait_step(input string tag, input logic [1:0] s, input int p);
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (q.size() != 0 && q[0].sel == s && q[0].ph == p) found = 1;
         else cycle();
      end
      chk(tag, 64'(found), 64'd1);
   endtask

   initial begin
      rst = 1; clear = 0; in_valid = 0; in_data = '0; out_ready = 1;
      model_reset();
      #3;
      chk("rst_dp_clear",  64'(dp_clear),  64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_en_xi2",    64'(en_xi2),    64'd0);
      chk("rst_sel",       64'(sel_xi2),   64'd0);
      chk("rst_x2",        64'(x2),        64'd0);
      chk("rst_phase",     64'(phase),     64'd0);
      cycle(); cycle();
      rst = 0;
      cycle();
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // First sample takes the single LOAD step
      send(XW'(5));
      chk("load_sel",  64'(sel_xi2), 64'd1);
      chk("load_en",   64'(en_xi2),  64'd1);
      chk("load_x2",   64'(x2),      64'd5);
      cycle();
      chk("load_ov",   64'(out_valid), 64'd1);
      drain("drain_first");

      // Second sample: seed then N_PHASES-1 accumulate steps
      send(XW'(3));
      drain("drain_second");

      // Backpressure in ACC phase 2
      send(XW'(7));
      wait_step("reach_acc2", 2'b11, 2);
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_en_frozen",    64'(en_xi2), 64'd0);
         chk("bp_phase_frozen", 64'(phase),  64'd2);
      end
      out_ready = 1;
      cycle();
      drain("drain_bp");

      // Soft clear in ACC phase 1 aborts; the next sample goes through LOAD again
      send(XW'(9));
      wait_step("reach_acc1", 2'b11, 1);
      clear = 1;
      cycle();
      clear = 0;
      cycle();
      chk("clr_dp_clear", 64'(dp_clear),  64'd0);
      send(XW'(11));
      chk("clr_load_path", 64'(sel_xi2), 64'd1);
      drain("drain_clear");

      // Continuous in_valid: accepts spaced exactly N_PHASES+1 cycles apart
      acc_cyc.delete();
      in_valid = 1;
      for (int i = 0; i < 26; i++) begin
         in_data = XW'({$urandom, $urandom});
         cycle();
      end
      in_valid = 0;
      chk("cont_accepts", 64'(acc_cyc.size() >= 5), 64'd1);
      for (int i = 1; i < acc_cyc.size(); i++)
         chk("cont_gap", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(NP + 1));
      drain("drain_cont");

      // Random traffic with backpressure and occasional clears
      for (int i = 0; i < 500; i++) begin
         in_valid  = ($urandom % 2) != 0;
         out_ready = ($urandom % 4) != 0;
         clear     = ($urandom % 64) == 0;
         in_data   = XW'({$urandom, $urandom});
         cycle();
      end
      clear = 0; in_valid = 0; out_ready = 1;
      drain("drain_random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
